uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bits/s.
REQ-003 Port clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit, synchronous active-high reset.
REQ-005 Port serial_in, input, 1 bit, asynchronous UART line; idle high; 8 data bits, LSB first, 1 stop bit.
REQ-006 Port data_out, output, 8 bits, last correctly received byte.
REQ-007 Port data_valid, output, 1 bit, one-clk pulse when data_out is updated.
REQ-008 Port frame_err, output, 1 bit, one-clk pulse on a bad stop bit.
REQ-009 Port parity_err, output, 1 bit, one-clk pulse on a parity mismatch; constant 0 when parity is disabled.
REQ-010 Port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 serial_in SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-012 Oversample tick: TICK_DIV = CLK_FREQ/(BAUD*16), truncated integer; the tick counter runs only while busy and clears on entry to START.
REQ-013 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP and WAIT_IDLE.
REQ-014 IDLE -> START on a synchronized falling edge (previous 1, current 0).
REQ-015 START: the line is sampled at tick 8. If low -> DATA and the tick count resets; if high (false start) -> IDLE with no output pulse.
REQ-016 DATA: each bit is sampled every 16 ticks from the start-bit mid-point; shifted in LSB first; -> PARITY or STOP after the 8th bit.
REQ-017 STOP: sampled 16 ticks after the last data or parity bit.
- Stop high, no parity error: data_out is loaded and data_valid pulses on the next clk -> IDLE.
- Stop low: frame_err pulses, data_out is held, data_valid stays low -> WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL hold until the synchronized line is high, then -> IDLE; a break (line held low) yields exactly one frame_err.
REQ-019 Output latency: data_valid is asserted exactly 1 clk after the stop-bit sample edge.
REQ-020 data_out SHALL hold its value between valid bytes; no handshake, and the consumer samples it on data_valid.
REQ-021 data_valid, frame_err and parity_err SHALL each be high for exactly one clk per frame and never simultaneously.
REQ-022 A falling edge seen in the same clk as the return to IDLE SHALL be accepted (back-to-back frames with no extra idle).

Reset
REQ-023 Reset SHALL force state IDLE and clear the counters and shift register.
REQ-024 On reset: data_out=8'h00, data_valid=0, frame_err=0, parity_err=0, busy=0, synchronizer flops=1.
REQ-025 Reset mid-frame SHALL abandon the frame without any pulse; reception restarts on the next falling edge after reset deasserts.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, when defined, inserts an even-parity bit after the data bits.
- PARITY state samples it 16 ticks after bit 7.
- Mismatch with a good stop bit: parity_err pulses instead of data_valid and data_out is held.
- Bad stop bit: frame_err takes precedence.
REQ-027 Without UART_RX_PARITY_EN: no PARITY state, the frame is 10 bits and parity_err is tied 0.

Verification
REQ-028 All scenarios use BAUD=115200 and CLK_FREQ=50000000, giving TICK_DIV=27 and a 432-clk bit.
REQ-029 Frame 0xA5 with a good stop bit -> data_out=8'hA5, one data_valid pulse 1 clk after the stop sample, busy low afterwards.
REQ-030 Two back-to-back frames 0x00 then 0xFF with zero idle gap -> two data_valid pulses, data_out 8'h00 then 8'hFF.
REQ-031 Frame 0x3C with the stop bit driven low -> one frame_err pulse, data_out keeps its prior value, no data_valid.
REQ-032 Line low for 200 clks, then high -> false start; no pulses, busy returns low, next frame 0x55 received correctly.
REQ-033 Line held low for 20 bit times -> exactly one frame_err, busy high until the line returns high.
REQ-034 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (wrong) -> one parity_err pulse, no data_valid.
REQ-035 reset asserted at data bit 4 -> all outputs return to reset values, no pulses; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, 1 stop bit, 16x oversampling.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int DATA_W   = 8;
    localparam int BIT_W    = $clog2(DATA_W);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state, state_nxt;

    logic              sync_p0, sync_p1, line_p2;
    logic              fall;
    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [3:0]        tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              sample_mid, sample_bit;
    logic              clr_cnt, shift_en, done_ok, done_ferr;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_ok, done_perr;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    // stage p0/p1: metastability synchronizer; p2: previous value for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            line_p2 <= 1'b1;
        end else begin
            sync_p0 <= serial_in;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;
        end
    end

    assign fall       = line_p2 & ~sync_p1;
    assign busy       = (state != IDLE);
    assign tick       = busy && (div_cnt == DIV_LAST);
    assign sample_mid = tick && (tick_cnt == 4'd7);
    assign sample_bit = tick && (tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (reset || clr_cnt || !busy)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_W'(1);
    end

    // tick_cnt wraps 15 -> 0, so each data bit lands 16 ticks after the previous one
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            tick_cnt <= 4'd0;
            bit_cnt  <= '0;
        end else begin
            if (tick)
                tick_cnt <= tick_cnt + 4'd1;
            if (shift_en)
                bit_cnt <= bit_cnt + BIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            shift_reg <= '0;
        else if (shift_en)
            shift_reg <= {sync_p1, shift_reg[DATA_W-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            par_bit <= 1'b0;
        else if (state == PARITY && sample_bit)
            par_bit <= sync_p1;
    end

    assign par_ok = (even_parity(shift_reg) == par_bit);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        done_ok   = 1'b0;
        done_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
        done_perr = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    clr_cnt   = 1'b1;
                end
            end
            START: begin
                if (sample_mid) begin
                    if (!sync_p1) begin
                        state_nxt = DATA;
                        clr_cnt   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (sample_bit) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_bit)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                if (sample_bit) begin
                    if (sync_p1) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_ok)
                            done_ok = 1'b1;
                        else
                            done_perr = 1'b1;
`else
                        done_ok = 1'b1;
`endif
                    end else begin
                        // a bad stop bit outranks any parity result
                        done_ferr = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync_p1)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // output stage: pulses appear one clk after the stop-bit sample edge
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= done_ok;
            frame_err  <= done_ferr;
            if (done_ok)
                data_out <= shift_reg;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= done_perr;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx; expected outcomes come from a frame-level
// model (byte, stop bit, parity) and the nominal mid-stop-bit time of each frame.
module tb_uart_rx;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int BIT_CLKS = 432;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS    = PAR_EN ? 11 : 10;
    localparam int STOP_OFS = (NBITS - 1) * BIT_CLKS + BIT_CLKS / 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, parity_err, busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = good byte, 1 = frame error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         checks = 0;
    int         errors = 0;
    int         overlap = 0;
    logic [7:0] last_good = 8'h00;

    always @(negedge clk) begin
        ev_t e;
        if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1)
            overlap++;
        e.data = data_out;
        e.t    = cyc;
        if (data_valid) begin e.kind = 0; obs_q.push_back(e); end
        if (frame_err)  begin e.kind = 1; obs_q.push_back(e); end
        if (parity_err) begin e.kind = 2; obs_q.push_back(e); end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        serial_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        ev_t e;
        e.t    = cyc;
        e.data = b;
        e.kind = !stop_v ? 1 : (PAR_EN && par_flip) ? 2 : 0;
        if (e.kind == 0)
            last_good = b;
        exp_q.push_back(e);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i], BIT_CLKS);
        if (PAR_EN)
            drive_bit((^b) ^ par_flip, BIT_CLKS);
        drive_bit(stop_v, BIT_CLKS);
    endtask

    task automatic compare_events(input string tag);
        int lat;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
            if (exp_q[i].kind == 0)
                check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
            lat = obs_q[i].t - exp_q[i].t;
            check($sformatf("%s_lat%0d_%0d", tag, i, lat), int'(lat >= STOP_OFS - 4 && lat <= STOP_OFS + 8), 1);
        end
        check({tag, "_dout"}, data_out, last_good);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, data_out, 0);
        check({tag, "_dv"},   data_valid, 0);
        check({tag, "_fe"},   frame_err, 0);
        check({tag, "_pe"},   parity_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        ev_t        e;
        logic [7:0] b;
        logic       stop_v;

        repeat (5) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        drive_bit(1'b1, BIT_CLKS);

        send_frame(8'hA5, 1'b1, 1'b0);
        drive_bit(1'b1, 100);
        compare_events("a5");
        check("a5_busy", busy, 0);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_bit(1'b1, 100);
        compare_events("b2b");

        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b1, BIT_CLKS);
        compare_events("stop_low");

        drive_bit(1'b0, 200);
        drive_bit(1'b1, 2 * BIT_CLKS);
        check("false_busy", busy, 0);
        compare_events("false_start");
        send_frame(8'h55, 1'b1, 1'b0);
        drive_bit(1'b1, 100);
        compare_events("after_false");

        // break: the line stays low for 20 bit times
        e.t = cyc; e.kind = 1; e.data = 8'h00;
        exp_q.push_back(e);
        drive_bit(1'b0, 20 * BIT_CLKS);
        check("break_busy_hi", busy, 1);
        drive_bit(1'b1, 10);
        check("break_busy_lo", busy, 0);
        compare_events("break");
        drive_bit(1'b1, BIT_CLKS);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, 100);
        compare_events("par_bad");
`endif

        // abandon a frame halfway through data bit 4
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS / 2);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        last_good = 8'h00;
        drive_bit(1'b1, BIT_CLKS);
        compare_events("midrst");
        send_frame(8'h81, 1'b1, 1'b0);
        drive_bit(1'b1, 100);
        compare_events("after_rst");

        for (int n = 0; n < 4; n++) begin
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_v, 1'($urandom_range(0, 1)));
            if (!stop_v || $urandom_range(0, 1) == 1)
                drive_bit(1'b1, BIT_CLKS);
        end
        drive_bit(1'b1, 100);
        compare_events("rand");

        check("no_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
